mpmc10_strm_fill: RTL and testbench

MPMC10_STRM_FILL -- requirements
Module: mpmc10_strm_fill

---
 rtl/mpmc10_pkg.sv | 20 ++
 rtl/mpmc10_strm_fill.sv | 142 ++++++++++++++
 tb/tb_mpmc10_strm_fill.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 stream-cache fill path.
package mpmc10_pkg;

  localparam int LINES_PER_BLK = 64;
  localparam int LINE_SHIFT    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INV   = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fill_state_e;

  // Byte address of line 'off' inside 1 KiB block 'blk'.
  function automatic logic [31:0] line_adr(input logic [21:0] blk, input logic [5:0] off);
    return {blk, off, {LINE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/mpmc10_strm_fill.sv
// Stream read cache block refill engine: invalidates the target block,
// issues one read per line, and writes returning lines into the cache in
// request order so the last line (which sets tag/valid) lands last.
module mpmc10_strm_fill
  import mpmc10_pkg::*;
#(
  parameter int WID   = 256,
  parameter int LINES = LINES_PER_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic [31:0]      miss_adr,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic [31:0]      mem_adr,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [WID-1:0]   mem_rdat,
  output logic             wr,
  output logic [31:0]      wadr,
  output logic [WID-1:0]   wdat,
  output logic             inv
);

  localparam logic [6:0] LAST_REQ = 7'(LINES - 1);
  localparam logic [6:0] FULL_CNT = 7'(LINES);

  fill_state_e    state_q, state_d;
  logic [21:0]    blk_q, blk_d;
  logic [6:0]     req_cnt_q, req_cnt_d;
  logic [6:0]     rsp_cnt_q, rsp_cnt_d;
  logic           inv_q, inv_d;
  logic           wr_q, wr_d;
  logic [31:0]    wadr_q, wadr_d;
  logic [WID-1:0] wdat_q, wdat_d;

  logic start_s;
  logic accept_s;
  logic take_s;
  logic unused_adr_bits_s;

  // Only the block number of the missing address matters.
  assign unused_adr_bits_s = ^miss_adr[9:0];

  assign start_s  = (state_q == ST_IDLE) && miss;
  assign accept_s = (state_q == ST_FILL) && mem_ack;
  assign take_s   = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && mem_rvalid
                    && (rsp_cnt_q < FULL_CNT);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: DONE is entered only once every line has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_INV;
        else         state_d = ST_IDLE;
      end
      ST_INV:  state_d = ST_FILL;
      ST_FILL: begin
        if (accept_s && (req_cnt_q == LAST_REQ)) state_d = ST_DRAIN;
        else                                     state_d = ST_FILL;
      end
      ST_DRAIN: begin
        if (rsp_cnt_q == FULL_CNT) state_d = ST_DONE;
        else                       state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: block latch, saturating counters, cache write port.
  always_comb begin
    blk_d     = blk_q;
    req_cnt_d = req_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    inv_d     = 1'b0;
    wr_d      = 1'b0;
    wadr_d    = wadr_q;
    wdat_d    = wdat_q;
    if (start_s) begin
      blk_d     = miss_adr[31:10];
      req_cnt_d = 7'd0;
      rsp_cnt_d = 7'd0;
      inv_d     = 1'b1;
      wadr_d    = line_adr(miss_adr[31:10], 6'h00);
    end else begin
      if (accept_s && (req_cnt_q < FULL_CNT)) req_cnt_d = req_cnt_q + 7'd1;
      else                                     req_cnt_d = req_cnt_q;
      if (take_s) begin
        wr_d      = 1'b1;
        wdat_d    = mem_rdat;
        wadr_d    = line_adr(blk_q, rsp_cnt_q[5:0]);
        rsp_cnt_d = rsp_cnt_q + 7'd1;
      end else begin
        wr_d      = 1'b0;
      end
    end
  end

  // Datapath registers; reset abandons any fill in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q     <= 22'd0;
      req_cnt_q <= 7'd0;
      rsp_cnt_q <= 7'd0;
      inv_q     <= 1'b0;
      wr_q      <= 1'b0;
      wadr_q    <= 32'd0;
      wdat_q    <= {WID{1'b0}};
    end else begin
      blk_q     <= blk_d;
      req_cnt_q <= req_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      inv_q     <= inv_d;
      wr_q      <= wr_d;
      wadr_q    <= wadr_d;
      wdat_q    <= wdat_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign mem_req = (state_q == ST_FILL);
  assign mem_adr = (state_q == ST_FILL) ? line_adr(blk_q, req_cnt_q[5:0]) : 32'd0;
  assign inv     = inv_q;
  assign wr      = wr_q;
  assign wadr    = wadr_q;
  assign wdat    = wdat_q;

endmodule

// File: tb/tb_mpmc10_strm_fill.sv
// Bench for mpmc10_strm_fill: memory responder, transaction-level model
// checked every cycle, and directed fills with literal expectations.
module tb_mpmc10_strm_fill;

  localparam int WID = 256;

  logic           clk = 1'b0;
  logic           rst, miss, busy, done, mem_req, mem_ack, mem_rvalid, wr, inv;
  logic [31:0]    miss_adr, mem_adr, wadr;
  logic [WID-1:0] mem_rdat, wdat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpmc10_strm_fill #(.WID(WID), .LINES(64)) dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_adr(miss_adr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdat(mem_rdat),
    .wr(wr), .wadr(wadr), .wdat(wdat), .inv(inv)
  );

  // Data pattern returned by memory for line n of a block.
  function automatic logic [WID-1:0] pat(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(n);
    return {4{w, ~w}};
  endfunction

  task automatic chk(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          ack_mode = 0;   // 0: ack always, 1: ack 50 %
  int          rv_mode  = 0;   // 0: rvalid exactly 3 cycles after accept, 1: bursty
  bit          stray_req = 1'b0;
  int          cyc = 0;
  logic [31:0] pend_adr[$];
  int          pend_rdy[$];
  logic [31:0] acc_log[$];

  initial begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdat   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mem_req && mem_ack && !rst) begin
        acc_log.push_back(mem_adr);
        pend_adr.push_back(mem_adr);
        pend_rdy.push_back(cyc + ((rv_mode == 0) ? 3 : int'($urandom_range(1, 6))));
      end
      mem_rvalid = 1'b0;
      if (pend_adr.size() > 0 && pend_rdy[0] <= cyc &&
          (rv_mode == 0 || $urandom_range(0, 3) != 0)) begin
        mem_rvalid = 1'b1;
        mem_rdat   = pat(int'((pend_adr[0] >> 4) & 32'h3F));
        void'(pend_adr.pop_front());
        void'(pend_rdy.pop_front());
      end else if (stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdat   = pat(99);
        stray_req  = 1'b0;
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  // phase: 0 idle, 1 invalidate, 2 requesting, 3 draining, 4 done pulse
  int             m_phase = 0, m_nreq = 0, m_nrsp = 0;
  logic [31:0]    m_base = 32'd0;
  bit             e_wr = 1'b0, e_inv = 1'b0;
  logic [31:0]    e_wadr = 32'd0;
  logic [WID-1:0] e_wdat = '0;
  logic [31:0]    wr_adr_log[$];
  logic [WID-1:0] wr_dat_log[$];
  logic [31:0]    inv_log[$];
  int             done_cnt = 0;
  int             wr_at_done = -1;

  initial begin
    int ph0, rs0;
    forever begin
      @(posedge clk);
      e_wr  = 1'b0;
      e_inv = 1'b0;
      if (rst) begin
        m_phase = 0; m_nreq = 0; m_nrsp = 0; m_base = 32'd0;
        e_wadr = 32'd0; e_wdat = '0;
      end else begin
        ph0 = m_phase;
        rs0 = m_nrsp;
        if (ph0 == 0 && miss) begin
          m_base  = miss_adr & 32'hFFFF_FC00;
          m_nreq  = 0;
          m_nrsp  = 0;
          e_inv   = 1'b1;
          e_wadr  = m_base;
          m_phase = 1;
        end else if (ph0 == 1) begin
          m_phase = 2;
        end else if (ph0 == 4) begin
          m_phase = 0;
        end
        if ((ph0 == 2 || ph0 == 3) && mem_rvalid && m_nrsp < 64) begin
          e_wr   = 1'b1;
          e_wdat = mem_rdat;
          e_wadr = m_base + 32'(m_nrsp * 16);
          m_nrsp++;
        end
        if (ph0 == 2 && mem_ack) begin
          m_nreq++;
          if (m_nreq == 64) m_phase = 3;
        end
        if (ph0 == 3 && rs0 == 64) m_phase = 4;
      end
      #1;
      chk("ctl{busy,done,req,wr,inv}", 256'({busy, done, mem_req, wr, inv}),
          256'({m_phase != 0, m_phase == 4, m_phase == 2, e_wr, e_inv}));
      if (m_phase == 2) chk("mem_adr", 256'(mem_adr), 256'(m_base + 32'(m_nreq * 16)));
      if (e_wr || e_inv) chk("wadr", 256'(wadr), 256'(e_wadr));
      if (e_wr) chk("wdat", wdat, e_wdat);
      if (wr) begin
        wr_adr_log.push_back(wadr);
        wr_dat_log.push_back(wdat);
      end
      if (inv) inv_log.push_back(wadr);
      if (done) begin
        done_cnt++;
        wr_at_done = wr_adr_log.size();
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic clear_logs();
    wr_adr_log.delete(); wr_dat_log.delete(); inv_log.delete(); acc_log.delete();
    done_cnt = 0; wr_at_done = -1;
  endtask

  task automatic pulse_miss(input logic [31:0] adr);
    @(negedge clk);
    miss = 1'b1; miss_adr = adr;
    @(negedge clk);
    miss = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 256'(done_cnt > 0), 256'(1'b1));
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 256'(acc_log.size() >= n), 256'(1'b1));
  endtask

  task automatic check_fill(input logic [31:0] base, input string tag);
    chk({tag, "_inv_cnt"}, 256'(inv_log.size()), 256'(1));
    if (inv_log.size() > 0) chk({tag, "_inv_adr"}, 256'(inv_log[0]), 256'(base));
    chk({tag, "_req_cnt"}, 256'(acc_log.size()), 256'(64));
    chk({tag, "_wr_cnt"}, 256'(wr_adr_log.size()), 256'(64));
    chk({tag, "_wr_before_done"}, 256'(wr_at_done), 256'(64));
    for (int i = 0; i < 64; i++) begin
      if (i < acc_log.size()) chk({tag, "_req_adr"}, 256'(acc_log[i]), 256'(base + 32'(i * 16)));
      if (i < wr_adr_log.size()) begin
        chk({tag, "_wr_adr"}, 256'(wr_adr_log[i]), 256'(base + 32'(i * 16)));
        chk({tag, "_wr_dat"}, wr_dat_log[i], pat(i));
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; miss = 1'b0; miss_adr = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 256'({busy, done, mem_req, wr, inv}), 256'(5'b0));
    chk("rst_adr", 256'({mem_adr, wadr}), 256'(64'd0));
    chk("rst_wdat", wdat, '0);
    rst = 1'b0;

    // A: ack always, rvalid 3 cycles after accept
    clear_logs();
    pulse_miss(32'h0001_2345);
    wait_done(400, "A_done_timeout");
    check_fill(32'h0001_2000, "A");
    if (inv_log.size() > 0) chk("A_inv_literal", 256'(inv_log[0]), 256'(32'h0001_2000));
    if (acc_log.size() == 64) chk("A_last_req_literal", 256'(acc_log[63]), 256'(32'h0001_23F0));
    if (wr_adr_log.size() == 64) chk("A_last_wr_literal", 256'(wr_adr_log[63]), 256'(32'h0001_23F0));
    repeat (3) @(negedge clk);

    // B: random ack, bursty rvalid, a second miss while filling
    clear_logs();
    ack_mode = 1; rv_mode = 1;
    pulse_miss(32'h0ABC_D7F8);
    wait_acc(5, 200, "B_acc_timeout");
    pulse_miss(32'h5555_0000);
    wait_done(3000, "B_done_timeout");
    check_fill(32'h0ABC_D400, "B");
    repeat (20) @(negedge clk);
    chk("B_single_done", 256'(done_cnt), 256'(1));
    chk("B_no_second_fill", 256'({busy, 7'(inv_log.size())}), 256'({1'b0, 7'd1}));
    ack_mode = 0; rv_mode = 0;

    // C: stray rvalid while idle
    clear_logs();
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("C_stray_no_wr", 256'(wr_adr_log.size()), 256'(0));
    chk("C_stray_idle", 256'(busy), 256'(1'b0));

    // D: reset after 20 accepts, late responses ignored, clean refill of same block
    clear_logs();
    pulse_miss(32'h0001_2345);
    wait_acc(20, 200, "D_acc_timeout");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("D_rst_ctl", 256'({busy, done, mem_req, wr, inv}), 256'(5'b0));
    chk("D_rst_adr", 256'({mem_adr, wadr}), 256'(64'd0));
    chk("D_rst_wdat", wdat, '0);
    clear_logs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("D_late_rsp_no_wr", 256'(wr_adr_log.size()), 256'(0));
    chk("D_idle_after_rst", 256'(busy), 256'(1'b0));
    clear_logs();
    pulse_miss(32'h0001_2345);
    wait_done(400, "D_done_timeout");
    check_fill(32'h0001_2000, "D");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
